// File: rtl/bfloat_div_seq.sv
// Iterative bfloat16 divider c = a / b: restoring divider, one quotient bit per cycle, round to nearest-even.
// Optional BF_DIV_FLAGS_EN adds flags[3:0] = {invalid, divzero, overflow, underflow}.
`timescale 1ns/1ps
module bfloat_div_seq #(
  parameter int QBITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c,
  output logic        busy
`ifdef BF_DIV_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0]       a_r, b_r;
  logic signed [9:0] exp_r;
  logic [9:0]        rem_r;
  logic [QBITS-1:0]  q_r;
  logic [7:0]        mb_r;
  logic [3:0]        cnt_r;

  logic [7:0] a_exp, b_exp;
  logic [6:0] a_man, b_man;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic       res_sign, is_special, special_nan, special_inf, div_zero;
  logic [15:0] special_val;
  logic [7:0] ma, mb;
  logic signed [9:0] exp_base;

  logic       rem_ge;
  logic [9:0] rem_sub, rem_next;

  logic       round_up;
  logic [8:0] sig_rnd;
  logic       carry;
  logic [6:0] man_rnd;
  logic signed [9:0] exp_rnd;
  logic       ovf, unf;
  logic [15:0] round_val;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Operand classification; subnormals share exponent 0 and are treated as zero.
  assign a_exp  = a_r[14:7];
  assign b_exp  = b_r[14:7];
  assign a_man  = a_r[6:0];
  assign b_man  = b_r[6:0];
  assign a_zero = (a_exp == 8'h00);
  assign b_zero = (b_exp == 8'h00);
  assign a_inf  = (a_exp == 8'hFF) && (a_man == 7'h00);
  assign b_inf  = (b_exp == 8'hFF) && (b_man == 7'h00);
  assign a_nan  = (a_exp == 8'hFF) && (a_man != 7'h00);
  assign b_nan  = (b_exp == 8'hFF) && (b_man != 7'h00);

  assign res_sign    = a_r[15] ^ b_r[15];
  assign is_special  = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
  assign special_nan = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign special_inf = a_inf | b_zero;
  assign div_zero    = b_zero & ~a_zero & ~a_nan;

  assign special_val = special_nan ? 16'hFFFF :
                       special_inf ? {res_sign, 8'hFF, 7'h00} :
                                     {res_sign, 15'h0000};

  assign ma       = {1'b1, a_man};
  assign mb       = {1'b1, b_man};
  assign exp_base = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;

  assign rem_ge   = (rem_r >= {2'b00, mb_r});
  assign rem_sub  = rem_ge ? (rem_r - {2'b00, mb_r}) : rem_r;
  assign rem_next = rem_sub << 1;

  // q_r holds 1.7 significand plus guard; a carry to 2.0 renormalises right by one.
  assign round_up  = q_r[0] & ((rem_r != 10'd0) | q_r[1]);
  assign sig_rnd   = {1'b0, q_r[QBITS-1:1]} + {8'd0, round_up};
  assign carry     = sig_rnd[8];
  assign man_rnd   = carry ? sig_rnd[7:1] : sig_rnd[6:0];
  assign exp_rnd   = exp_r + $signed({9'd0, carry});
  assign ovf       = (exp_rnd >= 10'sd255);
  assign unf       = (exp_rnd <= 10'sd0);
  assign round_val = ovf ? {res_sign, 8'hFF, 7'h00} :
                     unf ? {res_sign, 15'h0000} :
                           {res_sign, exp_rnd[7:0], man_rnd};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = PREP;
      PREP:    state_nxt = is_special ? DONE : DIV;
      DIV:     if (cnt_r == 4'd0) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; the result is only ever loaded on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= 16'h0000;
      b_r       <= 16'h0000;
      exp_r     <= 10'sd0;
      rem_r     <= 10'd0;
      q_r       <= '0;
      mb_r      <= 8'd0;
      cnt_r     <= 4'd0;
      c         <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
          end
        end
        PREP: begin
          if (is_special) begin
            c         <= special_val;
            out_valid <= 1'b1;
          end else begin
            // Pre-scale so the quotient lands in [1,2).
            if (ma < mb) begin
              rem_r <= {1'b0, ma, 1'b0};
              exp_r <= exp_base - 10'sd1;
            end else begin
              rem_r <= {2'b00, ma};
              exp_r <= exp_base;
            end
            mb_r  <= mb;
            q_r   <= '0;
            cnt_r <= 4'(QBITS - 1);
          end
        end
        DIV: begin
          rem_r <= rem_next;
          q_r   <= {q_r[QBITS-2:0], rem_ge};
          cnt_r <= cnt_r - 4'd1;
        end
        ROUND: begin
          c         <= round_val;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef BF_DIV_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (state == PREP && is_special) begin
      flags <= {special_nan, div_zero, 2'b00};
    end else if (state == ROUND) begin
      flags <= {1'b0, 1'b0, ovf, unf & ~ovf};
    end
  end
`endif

endmodule

// File: tb/tb_bfloat_div_seq.sv
// Directed self-checking bench for bfloat_div_seq with hand-computed quotients and latencies.
`timescale 1ns/1ps
module tb_bfloat_div_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c;
  logic        busy;
`ifdef BF_DIV_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks;
  int errors;

  bfloat_div_seq dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c(c),
    .busy(busy)
`ifdef BF_DIV_FLAGS_EN
    ,
    .flags(flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual %h required %h", tag, actual, expected);
    end
  endtask

  // One op: latency counts edges from the acceptance edge (inclusive) to out_valid high.
  task automatic applyStimulus(input logic [15:0] op_a, input logic [15:0] op_b,
                               input logic [15:0] exp_c, input int exp_lat,
                               input logic [3:0] exp_flags, input string tag);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    a = op_a;
    b = op_b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'hA5A5;
    b = 16'h5A5A;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_c"}, {16'h0, c}, {16'h0, exp_c});
`ifdef BF_DIV_FLAGS_EN
    checkOutput({tag, "_flags"}, {28'h0, flags}, {28'h0, exp_flags});
`endif
    if (out_ready) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_drain"}, {31'h0, out_valid}, 32'h0);
    end
  endtask

  initial begin
    int seen;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_c", {16'h0, c}, 32'h0);
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'h3F80, 16'h4000, 16'h3F00, 12, 4'b0000, "one_half");
    applyStimulus(16'h3F80, 16'h4040, 16'h3EAB, 12, 4'b0000, "one_third");
    applyStimulus(16'hC0C0, 16'h3FC0, 16'hC080, 12, 4'b0000, "neg6_1p5");
    applyStimulus(16'h40A0, 16'h4040, 16'h3FD5, 12, 4'b0000, "five_third");
    applyStimulus(16'h0000, 16'h0000, 16'hFFFF, 2, 4'b1000, "zero_zero");
    applyStimulus(16'hC000, 16'h0000, 16'hFF80, 2, 4'b0100, "div_zero");
    applyStimulus(16'h7F80, 16'h4000, 16'h7F80, 2, 4'b0000, "inf_fin");
    applyStimulus(16'h3F80, 16'h7F80, 16'h0000, 2, 4'b0000, "fin_inf");
    applyStimulus(16'h7FC1, 16'h3F80, 16'hFFFF, 2, 4'b1000, "nan_op");
    applyStimulus(16'h7F00, 16'h3E80, 16'h7F80, 12, 4'b0010, "overflow");
    applyStimulus(16'h0080, 16'h4000, 16'h0000, 12, 4'b0001, "underflow");

    // Backpressure: result must hold while stray in_valid pulses are ignored.
    out_ready = 1'b0;
    applyStimulus(16'h40A0, 16'h4040, 16'h3FD5, 12, 4'b0000, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'h4000;
      b = 16'h3F80;
      @(posedge clk);
      #1;
      checkOutput("bp_hold_c", {16'h0, c}, 32'h3FD5);
      checkOutput("bp_hold_valid", {31'h0, out_valid}, 32'h1);
      checkOutput("bp_in_ready", {31'h0, in_ready}, 32'h0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("bp_release_ready", {31'h0, in_ready}, 32'h1);
    applyStimulus(16'hC0C0, 16'h3FC0, 16'hC080, 12, 4'b0000, "b2b");

    // Reset in the fourth DIV cycle discards the in-flight op.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h3F80;
    b = 16'h4040;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("abort_c", {16'h0, c}, 32'h0);
    checkOutput("abort_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    checkOutput("abort_no_result", seen, 32'h0);
    applyStimulus(16'h4000, 16'h3F80, 16'h4000, 12, 4'b0000, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
